mem_port_arbiter: RTL and testbench

Two-requester arbiter and byte sequencer for the byte-organised 4 KiB data memory. Port 0 (load/store unit) and port 1 (debug/DMA loader) issue 32-bit word requests. The block grants one request at a time, round-robin, and moves the word as four little-endian byte beats over the memory's single byte-wide port. It sits between the execute stage and the data memory array, replacing direct multi-byte access with a sequenced, shared one.

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter that moves 32-bit words as four little-endian byte
// beats over a single byte-wide memory port.
module mem_port_arbiter #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid_i,
  input  logic              p0_we_i,
  input  logic [31:0]       p0_addr_i,
  input  logic [31:0]       p0_wdata_i,
  output logic              p0_ready_o,
  input  logic              p1_valid_i,
  input  logic              p1_we_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [31:0]       p1_wdata_i,
  output logic              p1_ready_o,
  output logic              resp_valid_o,
  output logic              resp_id_o,
  output logic [31:0]       resp_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              mem_we_o,
  input  logic [7:0]        mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic              last_id_q, last_id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              id_q, id_d;
  logic [23:0]       cap_q, cap_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic              gnt0, gnt1;
  logic [7:0]        wbyte;

  // On a tie the port that did not own the last response wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      if (p0_valid_i && p1_valid_i) begin
        gnt0 = last_id_q;
        gnt1 = ~last_id_q;
      end else begin
        gnt0 = p0_valid_i;
        gnt1 = p1_valid_i;
      end
    end
  end

  assign p0_ready_o = gnt0;
  assign p1_ready_o = gnt1;

  always_comb begin
    wbyte = 8'h00;
    case (k_q)
      2'd0: wbyte = wdata_q[7:0];
      2'd1: wbyte = wdata_q[15:8];
      2'd2: wbyte = wdata_q[23:16];
      2'd3: wbyte = wdata_q[31:24];
      default: wbyte = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    last_id_d    = last_id_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    id_d         = id_q;
    cap_d        = cap_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          id_d    = gnt1;
          we_d    = gnt1 ? p1_we_i : p0_we_i;
          addr_d  = gnt1 ? p1_addr_i[ADDR_W-1:0] : p0_addr_i[ADDR_W-1:0];
          wdata_d = gnt1 ? p1_wdata_i : p0_wdata_i;
          k_d     = 2'd0;
          cap_d   = 24'h000000;
          state_d = BEAT;
        end
      end
      BEAT: begin
        if (!we_q) begin
          case (k_q)
            2'd0: cap_d[7:0]   = mem_rdata_i;
            2'd1: cap_d[15:8]  = mem_rdata_i;
            2'd2: cap_d[23:16] = mem_rdata_i;
            default: cap_d     = cap_q;
          endcase
        end
        if (k_q == 2'd3) begin
          // The response word is registered here so it can hold until the next RESP.
          resp_rdata_d = we_q ? 32'h00000000 : {mem_rdata_i, cap_q};
          k_d          = 2'd0;
          state_d      = RESP;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      RESP: begin
        last_id_d = id_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= 2'd0;
      last_id_q    <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h00000000;
      id_q         <= 1'b0;
      cap_q        <= 24'h000000;
      resp_rdata_q <= 32'h00000000;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      last_id_q    <= last_id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      id_q         <= id_d;
      cap_q        <= cap_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = 8'h00;
    mem_we_o    = 1'b0;
    if (state_q == BEAT) begin
      mem_addr_o  = addr_q + {{(ADDR_W-2){1'b0}}, k_q};
      mem_wdata_o = wbyte;
      mem_we_o    = we_q;
    end
  end

  assign resp_valid_o = (state_q == RESP);
  assign resp_id_o    = (state_q == RESP) ? id_q : 1'b0;
  assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter: a byte-array memory plus a
// transaction-level reference model predicting grants, beats and responses.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0Valid = 1'b0, p0We = 1'b0, p1Valid = 1'b0, p1We = 1'b0;
  logic [31:0] p0Addr = '0, p0Wdata = '0, p1Addr = '0, p1Wdata = '0;
  logic        p0Ready, p1Ready, respValid, respId, memWe;
  logic [31:0] respRdata;
  logic [11:0] memAddr;
  logic [7:0]  memWdata, memRdata;

  mem_port_arbiter #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .p0_valid_i(p0Valid), .p0_we_i(p0We), .p0_addr_i(p0Addr), .p0_wdata_i(p0Wdata), .p0_ready_o(p0Ready),
    .p1_valid_i(p1Valid), .p1_we_i(p1We), .p1_addr_i(p1Addr), .p1_wdata_i(p1Wdata), .p1_ready_o(p1Ready),
    .resp_valid_o(respValid), .resp_id_o(respId), .resp_rdata_o(respRdata),
    .mem_addr_o(memAddr), .mem_wdata_o(memWdata), .mem_we_o(memWe), .mem_rdata_i(memRdata)
  );

  always #5 clk = ~clk;

  // Environment memory and the model's own view of what it should contain.
  logic [7:0] tbMem  [0:4095];
  logic [7:0] refMem [0:4095];
  assign memRdata = tbMem[memAddr];
  always @(posedge clk) if (memWe) tbMem[memAddr] <= memWdata;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t        qExp[$];
  int          hsLog[$];
  int          hsCyc[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          nextFree = 0;
  logic        lastIdM = 1'b1;
  logic [31:0] lastRespM = '0;
  logic        actValid = 1'b0, actWe = 1'b0;
  logic [31:0] actAddr = '0, actWdata = '0;
  int          actStart = 0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: grant rules, byte beats and expected responses per cycle.
  always @(negedge clk) begin
    int          k;
    int          gp;
    logic [11:0] ea;
    logic [1:0]  g;
    logic [7:0]  eb;
    exp_t        e;
    if (rst) begin
      checkOutput("resetOutputs", {8'h0, p0Ready, p1Ready, respValid, respId, respRdata, memAddr, memWdata, memWe}, 64'h0);
      qExp.delete();
      lastIdM  = 1'b1;
      nextFree = cyc;
      actValid = 1'b0;
    end else begin
      if (actValid && cyc >= actStart + 1 && cyc <= actStart + 4) begin
        k  = cyc - actStart - 1;
        ea = 12'((actAddr + k) % 4096);
        eb = actWdata[8*k +: 8];
        checkOutput("memBeat", {memWe, memAddr, memWdata}, {actWe, ea, eb});
        if (actWe) refMem[ea] = eb;
      end else begin
        checkOutput("memIdle", {memWe, memAddr, memWdata}, 21'h0);
      end
      g  = 2'b00;
      gp = -1;
      if (cyc >= nextFree) begin
        if (p0Valid && p1Valid) gp = lastIdM ? 0 : 1;
        else if (p0Valid) gp = 0;
        else if (p1Valid) gp = 1;
      end
      if (gp >= 0) g[gp] = 1'b1;
      checkOutput("ready", {p1Ready, p0Ready}, g);
      if (gp >= 0) begin
        actValid = 1'b1;
        actStart = cyc;
        actWe    = (gp == 1) ? p1We : p0We;
        actAddr  = (gp == 1) ? p1Addr : p0Addr;
        actWdata = (gp == 1) ? p1Wdata : p0Wdata;
        e.id    = (gp == 1);
        e.due   = cyc + 5;
        e.rdata = '0;
        if (!actWe)
          for (int b = 0; b < 4; b++) e.rdata[8*b +: 8] = refMem[(actAddr + b) % 4096];
        qExp.push_back(e);
        lastIdM  = (gp == 1);
        nextFree = cyc + 6;
        hsLog.push_back(gp);
        hsCyc.push_back(cyc);
      end
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      lastRespM = '0;
    end else if (respValid) begin
      if (qExp.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedResp: got id %0d data %h, required no response", respId, respRdata);
      end else begin
        e = qExp.pop_front();
        checkOutput("respId", respId, e.id);
        checkOutput("respRdata", respRdata, e.rdata);
        checkOutput("respCycle", cyc, e.due);
        lastRespM = e.rdata;
      end
    end else begin
      checkOutput("respHold", respRdata, lastRespM);
      if (qExp.size() != 0 && qExp[0].due < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL missingResp: got none, required id %0d by cycle %0d", qExp[0].id, qExp[0].due);
        void'(qExp.pop_front());
      end
    end
  end

  task automatic applyStimulus(input int port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int   budget = 0;
    logic rdy;
    @(posedge clk); #1;
    if (port == 0) begin p0Valid = 1; p0We = we; p0Addr = addr; p0Wdata = wdata; end
    else           begin p1Valid = 1; p1We = we; p1Addr = addr; p1Wdata = wdata; end
    do begin
      @(negedge clk);
      budget++;
      rdy = (port == 0) ? p0Ready : p1Ready;
    end while (!rdy && budget < 100);
    checkOutput("handshakeTimeout", rdy, 1'b1);
    @(posedge clk); #1;
    if (port == 0) p0Valid = 0; else p1Valid = 0;
  endtask

  task automatic waitIdle();
    int b = 0;
    while (qExp.size() != 0 && b < 100) begin
      @(negedge clk);
      b++;
    end
    checkOutput("drainTimeout", b < 100, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic doReset();
    @(posedge clk); #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [7:0]  old22, old23;
    logic [31:0] a;
    for (int i = 0; i < 4096; i++) begin
      tbMem[i]  = 8'($urandom);
      refMem[i] = tbMem[i];
    end
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Basic store then load on port 0.
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF);
    waitIdle();
    checkOutput("basicStoreBytes", {tbMem[16'h13], tbMem[16'h12], tbMem[16'h11], tbMem[16'h10]}, 32'hDEADBEEF);
    applyStimulus(0, 1'b0, 32'h10, 32'h0);
    waitIdle();
    checkOutput("basicLoad", respRdata, 32'hDEADBEEF);

    // Continuous tie from reset alternates 0,1,0,1 with 6-cycle spacing.
    doReset();
    n = hsLog.size();
    fork
      begin applyStimulus(0, 1'b0, 32'h100, 0); applyStimulus(0, 1'b0, 32'h104, 0); end
      begin applyStimulus(1, 1'b0, 32'h200, 0); applyStimulus(1, 1'b0, 32'h204, 0); end
    join
    waitIdle();
    checkOutput("tieOrder", {hsLog[n], hsLog[n+1], hsLog[n+2], hsLog[n+3]}, {32'd0, 32'd1, 32'd0, 32'd1});
    for (int i = 1; i < 4; i++) checkOutput("tieSpacing", hsCyc[n+i] - hsCyc[n+i-1], 6);

    // Wrap-around at the top of memory.
    applyStimulus(0, 1'b1, 32'hFFE, 32'h11223344);
    waitIdle();
    checkOutput("wrapBytes", {tbMem[1], tbMem[0], tbMem[12'hFFF], tbMem[12'hFFE]}, 32'h11223344);
    applyStimulus(1, 1'b0, 32'hFFE, 0);
    waitIdle();
    checkOutput("wrapLoad", respRdata, 32'h11223344);

    // Upper address bits are ignored.
    applyStimulus(1, 1'b0, 32'h00001010, 0);
    waitIdle();
    checkOutput("truncLoad", respRdata, 32'hDEADBEEF);

    // Reset during beat k=2 of a store.
    old22 = tbMem[12'h22];
    old23 = tbMem[12'h23];
    applyStimulus(0, 1'b1, 32'h20, 32'hAABBCCDD);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (3) @(negedge clk);
    checkOutput("abortBytes", {tbMem[12'h23], tbMem[12'h22], tbMem[12'h21], tbMem[12'h20]}, {old23, old22, 8'hCC, 8'hDD});
    n = hsLog.size();
    fork
      applyStimulus(0, 1'b0, 32'h20, 0);
      applyStimulus(1, 1'b0, 32'h24, 0);
    join
    waitIdle();
    checkOutput("abortTieWinner", hsLog[n], 0);

    // Port 1 arrives while port 0 is busy and waits for IDLE.
    n = hsLog.size();
    fork
      applyStimulus(0, 1'b1, 32'h40, 32'h5A5AC3C3);
      begin repeat (3) @(posedge clk); applyStimulus(1, 1'b0, 32'h40, 0); end
    join
    waitIdle();
    checkOutput("heldOrder", {hsLog[n], hsLog[n+1]}, {32'd0, 32'd1});
    checkOutput("heldSpacing", hsCyc[n+1] - hsCyc[n], 6);
    checkOutput("heldLoad", respRdata, 32'h5A5AC3C3);

    // A request withdrawn while the block is busy is never granted.
    n = hsLog.size();
    fork
      applyStimulus(0, 1'b1, 32'h50, 32'h01020304);
      begin
        repeat (2) @(posedge clk);
        #1 p1Valid = 1; p1We = 0; p1Addr = 32'h50;
        repeat (2) @(posedge clk);
        #1 p1Valid = 0;
      end
    join
    waitIdle();
    checkOutput("withdrawCount", hsLog.size() - n, 1);

    // Randomised traffic from both ports.
    fork
      for (int i = 0; i < 30; i++) begin
        a = $urandom;
        if ($urandom_range(0, 3) == 0) a[11:0] = 12'hFFC + 12'($urandom_range(0, 3));
        else if ($urandom_range(0, 1) == 0) a[11:0] = 12'($urandom_range(0, 63));
        repeat ($urandom_range(0, 8)) @(posedge clk);
        applyStimulus(0, 1'($urandom), a, $urandom);
      end
      for (int j = 0; j < 30; j++) begin
        logic [31:0] b;
        b = $urandom;
        if ($urandom_range(0, 1) == 0) b[11:0] = 12'($urandom_range(0, 63));
        repeat ($urandom_range(0, 8)) @(posedge clk);
        applyStimulus(1, 1'($urandom), b, $urandom);
      end
    join
    waitIdle();

    n = 0;
    for (int i = 0; i < 4096; i++) if (tbMem[i] !== refMem[i]) n++;
    checkOutput("memImage", n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
